// File: rtl/dec_round_key_prep.sv
// Builds the AES-256 equivalent-inverse-cipher round keys from an expanded
// encryption key, one 32-bit word per clock, using a single InvMixColumns.
module dec_round_key_prep (
    input  logic          clk,
    input  logic          reset,
    input  logic [1919:0] exp_key,
    input  logic          exp_done,
    output logic [1919:0] dec_key,
    output logic          keys_ready,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFORM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic [5:0]      j_r, j_s;
    logic            cap_en_s, wr_en_s, ready_s;
    logic            keys_ready_r, busy_r;
    logic [1919:0]   cap_r, dec_key_r;
    logic [3:0]      r_s;
    logic [5:0]      src_idx_s;
    logic [10:0]     src_base_s, dst_base_s;
    logic [31:0]     src_word_s, mix_word_s, out_word_s;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // InvMixColumns on one column; byte b0 is the most significant byte.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
        logic [7:0] b [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            b[i]  = w[31 - 8*i -: 8];
            x2[i] = xtime(b[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m9[i] = x8[i] ^ b[i];
            mb[i] = x8[i] ^ x2[i] ^ b[i];
            md[i] = x8[i] ^ x4[i] ^ b[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        inv_mix_col = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                       m9[0] ^ me[1] ^ mb[2] ^ md[3],
                       md[0] ^ m9[1] ^ me[2] ^ mb[3],
                       mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // Word j takes round 14-r, same column, from the captured schedule.
    always_comb begin
        r_s        = j_r[5:2];
        src_idx_s  = {4'd14 - r_s, j_r[1:0]};
        src_base_s = 11'd1919 - {src_idx_s, 5'd0};
        dst_base_s = 11'd1919 - {j_r, 5'd0};
        src_word_s = cap_r[src_base_s -: 32];
        mix_word_s = inv_mix_col(src_word_s);
        if ((r_s == 4'd0) || (r_s == 4'd14)) begin
            out_word_s = src_word_s;
        end else begin
            out_word_s = mix_word_s;
        end
    end

    // Next-state, counter and control decode.
    always_comb begin
        state_s  = state_r;
        j_s      = j_r;
        cap_en_s = 1'b0;
        wr_en_s  = 1'b0;
        ready_s  = keys_ready_r;
        case (state_r)
            IDLE: begin
                if (exp_done) begin
                    state_s  = XFORM;
                    j_s      = 6'd0;
                    cap_en_s = 1'b1;
                end else begin
                    state_s  = IDLE;
                end
            end
            XFORM: begin
                wr_en_s = 1'b1;
                if (j_r == 6'd59) begin
                    state_s = DONE;
                    ready_s = 1'b1;
                end else begin
                    j_s = j_r + 6'd1;
                end
            end
            DONE: begin
                if (!exp_done) begin
                    state_s = IDLE;
                    ready_s = 1'b0;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
                j_s     = 6'd0;
                ready_s = 1'b0;
            end
        endcase
    end

    // State, counter and status flag registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= IDLE;
            j_r          <= 6'd0;
            keys_ready_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            j_r          <= j_s;
            keys_ready_r <= ready_s;
            busy_r       <= (state_s == XFORM);
        end
    end

    // Capture buffer and decryption key storage.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cap_r     <= 1920'd0;
            dec_key_r <= 1920'd0;
        end else begin
            if (cap_en_s) begin
                cap_r <= exp_key;
            end else begin
                cap_r <= cap_r;
            end
            if (wr_en_s) begin
                dec_key_r[dst_base_s -: 32] <= out_word_s;
            end else begin
                dec_key_r <= dec_key_r;
            end
        end
    end

    assign dec_key    = dec_key_r;
    assign keys_ready = keys_ready_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_dec_round_key_prep.sv
// Self-checking bench for dec_round_key_prep: reference AES-256 key expansion
// and equivalent-inverse-cipher model feeding a scoreboard queue.
module tb_dec_round_key_prep;

    logic          clk = 1'b0;
    logic          reset;
    logic [1919:0] exp_key;
    logic          exp_done;
    logic [1919:0] dec_key;
    logic          keys_ready;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;
    logic [1919:0] sb_q [$];

    typedef struct {
        logic [1919:0] key;
        logic [1919:0] dk;
    } vec_t;
    vec_t vecs [4];

    dec_round_key_prep dut (
        .clk        (clk),
        .reset      (reset),
        .exp_key    (exp_key),
        .exp_done   (exp_done),
        .dec_key    (dec_key),
        .keys_ready (keys_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] invmix(input logic [31:0] w);
        logic [7:0] b0 = w[31:24];
        logic [7:0] b1 = w[23:16];
        logic [7:0] b2 = w[15:8];
        logic [7:0] b3 = w[7:0];
        return {gmul(8'h0e, b0) ^ gmul(8'h0b, b1) ^ gmul(8'h0d, b2) ^ gmul(8'h09, b3),
                gmul(8'h09, b0) ^ gmul(8'h0e, b1) ^ gmul(8'h0b, b2) ^ gmul(8'h0d, b3),
                gmul(8'h0d, b0) ^ gmul(8'h09, b1) ^ gmul(8'h0e, b2) ^ gmul(8'h0b, b3),
                gmul(8'h0b, b0) ^ gmul(8'h0d, b1) ^ gmul(8'h09, b2) ^ gmul(8'h0e, b3)};
    endfunction

    function automatic logic [1919:0] expand(input logic [255:0] k);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc = 8'h01;
        logic [1919:0] out = 1920'd0;
        for (int i = 0; i < 60; i++) begin
            if (i < 8) begin
                w[i] = k[255 - 32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % 8 == 0) begin
                    t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                    rc = gmul(rc, 8'h02);
                end else if (i % 8 == 4) begin
                    t = subword(t);
                end
                w[i] = w[i-8] ^ t;
            end
            out[1919 - 32*i -: 32] = w[i];
        end
        return out;
    endfunction

    function automatic logic [1919:0] dec_model(input logic [1919:0] key);
        logic [1919:0] out = 1920'd0;
        logic [31:0]   s;
        int r, c;
        for (int k = 0; k < 60; k++) begin
            r = k / 4;
            c = k % 4;
            s = key[1919 - 32*(4*(14 - r) + c) -: 32];
            out[1919 - 32*k -: 32] = (r == 0 || r == 14) ? s : invmix(s);
        end
        return out;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_w(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic check_key(input string name, input logic [1919:0] act, input logic [1919:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            for (int k = 0; k < 60; k++) begin
                if (act[1919 - 32*k -: 32] !== req[1919 - 32*k -: 32]) begin
                    $display("FAIL %s: word %0d got %h, expected %h", name, k,
                             act[1919 - 32*k -: 32], req[1919 - 32*k -: 32]);
                    break;
                end
            end
        end
    endtask

    task automatic pop_check(input string name);
        logic [1919:0] exp_dk;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got ready=%b, expected a queued schedule", name, keys_ready);
        end else begin
            exp_dk = sb_q.pop_front();
            check_key(name, dec_key, exp_dk);
        end
    endtask

    // Start a pass from IDLE and wait (bounded) for keys_ready.
    task automatic run_pass(input string name, input logic [1919:0] key, input logic [1919:0] dk);
        int edges = 0;
        int busy_n = 0;
        exp_key  = key;
        exp_done = 1'b1;
        sb_q.push_back(dk);
        while (keys_ready !== 1'b1 && edges < 200) begin
            tick();
            edges++;
            if (busy === 1'b1) busy_n++;
        end
        check_w($sformatf("%s ready_edge", name), 128'(edges), 128'd61);
        check_w($sformatf("%s busy_cycles", name), 128'(busy_n), 128'd60);
        pop_check($sformatf("%s dec_key", name));
    endtask

    task automatic drop_done(input string name);
        exp_done = 1'b0;
        tick();
        check_w($sformatf("%s ready_after_drop", name), 128'(keys_ready), 128'd0);
    endtask

    initial begin
        logic [1919:0] fips, k1, mixed, junk;
        int edges, bad;

        fips = expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        vecs[0].key = fips;
        vecs[0].dk  = dec_model(fips);
        k1 = fips;
        k1[1919 - 32*4 -: 32] = 32'h8e4da1bc;
        k1[1919 - 32*5 -: 32] = 32'h01010101;
        vecs[1].key = k1;
        vecs[1].dk  = dec_model(k1);
        for (int i = 0; i < 60; i++) vecs[2].key[1919 - 32*i -: 32] = $urandom;
        vecs[2].dk  = dec_model(vecs[2].key);
        vecs[3].key = 1920'd0;
        vecs[3].dk  = 1920'd0;

        // Reset state
        reset = 1'b0; exp_done = 1'b0; exp_key = fips;
        tick(); tick();
        check_key("reset dec_key", dec_key, 1920'd0);
        check_w("reset keys_ready", 128'(keys_ready), 128'd0);
        check_w("reset busy", 128'(busy), 128'd0);
        reset = 1'b1;

        // Idle with exp_done low for 100 cycles
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (busy !== 1'b0 || keys_ready !== 1'b0) bad++;
        end
        check_w("idle_hold flags", 128'(bad), 128'd0);
        check_key("idle_hold dec_key", dec_key, 1920'd0);

        // Table-driven passes
        for (int v = 0; v < 4; v++) begin
            run_pass($sformatf("vec%0d", v), vecs[v].key, vecs[v].dk);
            if (v == 0) begin
                check_w("fips dk0", dec_key[1919 -: 128], 128'h24fc79ccbf0979e9371ac23c6d68de36);
                check_w("fips dk14", dec_key[127:0], 128'h000102030405060708090a0b0c0d0e0f);
            end
            if (v == 1) begin
                check_w("word52", 128'(dec_key[1919 - 32*52 -: 32]), 128'h db135345);
                check_w("word53", 128'(dec_key[1919 - 32*53 -: 32]), 128'h01010101);
            end
            bad = 0;
            for (int i = 0; i < 5; i++) begin
                tick();
                if (keys_ready !== 1'b1 || busy !== 1'b0) bad++;
            end
            check_w($sformatf("vec%0d done_hold", v), 128'(bad), 128'd0);
            check_key($sformatf("vec%0d done_hold dec_key", v), dec_key, vecs[v].dk);
            drop_done($sformatf("vec%0d", v));
        end

        // Partial pass keeps old words; exp_key/exp_done changes mid-pass ignored
        exp_key  = vecs[0].key;
        exp_done = 1'b1;
        sb_q.push_back(vecs[0].dk);
        edges = 0;
        repeat (11) begin tick(); edges++; end
        mixed = vecs[3].dk;
        mixed[1919 -: 320] = vecs[0].dk[1919 -: 320];
        check_key("partial old words", dec_key, mixed);
        repeat (20) begin tick(); edges++; end
        junk = ~vecs[0].key;
        exp_key  = junk;
        exp_done = 1'b0;
        tick(); edges++;
        exp_done = 1'b1;
        while (keys_ready !== 1'b1 && edges < 200) begin tick(); edges++; end
        check_w("midchange ready_edge", 128'(edges), 128'd61);
        pop_check("midchange dec_key");
        drop_done("midchange");

        // Reset at j=20 with exp_done held high, then fresh pass
        exp_key  = vecs[2].key;
        exp_done = 1'b1;
        repeat (21) tick();
        reset = 1'b0;
        tick();
        check_key("midreset dec_key", dec_key, 1920'd0);
        check_w("midreset keys_ready", 128'(keys_ready), 128'd0);
        check_w("midreset busy", 128'(busy), 128'd0);
        reset = 1'b1;
        run_pass("after_reset", vecs[2].key, vecs[2].dk);
        drop_done("after_reset");

        // Reset wins over the word-59 write
        exp_key  = vecs[1].key;
        exp_done = 1'b1;
        repeat (60) tick();
        reset = 1'b0;
        tick();
        check_w("reset_vs_last keys_ready", 128'(keys_ready), 128'd0);
        check_key("reset_vs_last dec_key", dec_key, 1920'd0);
        reset    = 1'b1;
        exp_done = 1'b0;
        repeat (3) tick();
        check_w("reset_vs_last idle busy", 128'(busy), 128'd0);

        // One-cycle drop in DONE, re-raise gives the same schedule
        run_pass("redo_a", vecs[1].key, vecs[1].dk);
        drop_done("redo");
        check_w("redo idle busy", 128'(busy), 128'd0);
        run_pass("redo_b", vecs[1].key, vecs[1].dk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dec_round_key_prep.md
DEC_ROUND_KEY_PREP -- requirements
Module: dec_round_key_prep

Interface
REQ-001 The block SHALL have these ports: clk  in  1  rising-edge clock for all state.
REQ-002 reset  in  1  synchronous, active-low; sampled only on the rising edge of clk.
REQ-003 exp_key  in  1920  expanded encryption key, words w0..w59; word i at bits [32i : 32i+31]; bit 0 is the MSB.
REQ-004 exp_done  in  1  level; high while exp_key is complete and stable.
REQ-005 dec_key  out  1920  decryption round keys dk0..dk14; dk r at bits [128r : 128r+127]; column c at [128r+32c : 128r+32c+31].
REQ-006 keys_ready  out  1  high while dec_key holds a complete, valid schedule.
REQ-007 busy  out  1  high while the transform is in progress.

Function
REQ-008 The block SHALL use three states: IDLE, XFORM and DONE.
REQ-009 In IDLE, at a clock edge where exp_done=1, the block SHALL:
- copy all 1920 bits of exp_key into an internal capture buffer;
- clear the word counter j to 0;
- enter XFORM.
REQ-010 In IDLE with exp_done=0, the block SHALL hold all state.
REQ-011 In XFORM, the block SHALL produce exactly one decryption word j per clock edge, for j = 0..59 in ascending order.
REQ-012 For word j, the block SHALL use r = j/4 and c = j mod 4; the source word SHALL be capture-buffer word 4*(14-r)+c.
REQ-013 For r = 0 and r = 14, the source word SHALL be written to dec_key unchanged.
REQ-014 For r = 1..13, the block SHALL apply InvMixColumns to the source word before writing it (equivalent inverse cipher).
REQ-015 InvMixColumns SHALL treat the word as column bytes b0..b3 (b0 = bits 0-7) and compute, in GF(2^8) with polynomial 0x11B:
- o0 = 0e·b0 ^ 0b·b1 ^ 0d·b2 ^ 09·b3
- o1, o2 and o3 by cyclic rotation of the coefficients.
REQ-016 InvMixColumns SHALL be a single-cycle combinational path between registers; exactly one instance SHALL exist.
REQ-017 XFORM SHALL read only the capture buffer; changes on exp_key or exp_done during XFORM SHALL be ignored.
REQ-018 On the edge that writes word 59, the block SHALL enter DONE and set keys_ready=1.
REQ-019 keys_ready SHALL rise exactly 61 rising edges after the IDLE edge that sampled exp_done=1.
REQ-020 busy SHALL be 1 exactly while the state is XFORM.
REQ-021 In DONE, dec_key and keys_ready SHALL hold for as long as exp_done=1.
REQ-022 In DONE, at an edge where exp_done=0, the block SHALL:
- clear keys_ready;
- return to IDLE;
- retain dec_key contents, which become invalid.
REQ-023 Re-entry from IDLE SHALL restart the full 60-word transform from j=0.
REQ-024 Words of dec_key not yet written in the current pass SHALL keep their previous values; they are valid only while keys_ready=1.
REQ-025 The word counter SHALL be 6 bits, SHALL never exceed 59, and SHALL not wrap.

Reset
REQ-026 When reset=0 at a clock edge, the block SHALL:
- enter IDLE;
- set j=0;
- set keys_ready=0 and busy=0;
- clear dec_key and the capture buffer to all zeros.
REQ-027 Reset SHALL take priority over every other event, including the word-59 write and exp_done sampling.
REQ-028 A reset mid-XFORM SHALL abort the pass with no further dec_key writes.
REQ-029 After reset is released, a new pass SHALL begin only once exp_done=1 is sampled in IDLE.

Verification
REQ-030 Bench SHALL drive FIPS-197 AES-256 key 000102…1f through the expansion, raise exp_done and check:
- dk0 = 24fc79cc bf0979e9 371ac23c 6d68de36;
- dk14 = 00010203 04050607 08090a0b 0c0d0e0f;
- keys_ready rises on the 61st edge.
REQ-031 Bench SHALL set w4 = 8e4da1bc and w5 = 01010101 and check:
- dec_key word 52 = db135345;
- dec_key word 53 = 01010101.
REQ-032 Bench SHALL change exp_key at j=30 during XFORM and check that dec_key matches the originally captured key and keys_ready timing is unchanged.
REQ-033 Bench SHALL assert reset=0 at j=20 and check:
- dec_key = 0 and keys_ready = busy = 0 on the next edge;
- with exp_done held at 1, a fresh pass completes 61 edges after reset release.
REQ-034 Bench SHALL hold exp_done=0 for 100 cycles and check that busy and keys_ready stay 0.
REQ-035 Bench SHALL drop exp_done for one cycle in DONE and check:
- keys_ready=0 on the next edge;
- on re-raise, a second pass produces identical dec_key.
